// File: rtl/cpu_sequencer_if.sv
// Fetch and data-memory handshake bundle for cpu_sequencer.
// master = sequencer side, slave = memory side.
interface cpu_sequencer_if #(
  parameter int unsigned REG_ADDR_W = 4
);
  localparam int unsigned INSTR_W = 4 + 3 * REG_ADDR_W;

  logic               i_req;
  logic               i_ack;
  logic [INSTR_W-1:0] i_data;
  logic               d_req;
  logic               d_we;
  logic               d_ack;

  modport master (
    output i_req,
    input  i_ack,
    input  i_data,
    output d_req,
    output d_we,
    input  d_ack
  );

  modport slave (
    input  i_req,
    output i_ack,
    output i_data,
    input  d_req,
    input  d_we,
    output d_ack
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer driving the cpu datapath strobes.
// Optional SEQ_SINGLE_STEP_EN adds a step input that gates each fetch after a retire.
module cpu_sequencer #(
  parameter int unsigned REG_ADDR_W  = 4,
  parameter int unsigned FLAG_W      = 16,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  cpu_sequencer_if.master       bus,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                  step,
`endif
  input  logic [FLAG_W-1:0]     flags,
  output logic                  reg1_read,
  output logic                  reg2_read,
  output logic                  reg3_write,
  output logic [REG_ADDR_W-1:0] reg1_addr,
  output logic [REG_ADDR_W-1:0] reg2_addr,
  output logic [REG_ADDR_W-1:0] reg3_addr,
  output logic [8:0]            lu_op,
  output logic                  pc_increment,
  output logic                  pc_load,
  output logic                  cmp_load,
  output logic                  cmp_compare,
  output logic                  halted,
  output logic                  fault,
  output logic [CNT_W-1:0]      instr_count
);
  localparam int unsigned INSTR_W = 4 + 3 * REG_ADDR_W;
  localparam int unsigned WAIT_W  = 16;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  state_t                state_q;
  logic [INSTR_W-1:0]    ir_q;
  logic [WAIT_W-1:0]     wait_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  i_req_q, d_req_q, d_we_q, mem_done_q;
  logic                  r1_q, r2_q, r3w_q, pcl_q, cmpl_q, cmpc_q;
  logic                  halted_q, fault_q;
  logic [8:0]            lu_q;
  logic [REG_ADDR_W-1:0] a1_q, a2_q, a3_q;

  logic [3:0]            op;
  logic [REG_ADDR_W-1:0] rd, rs1, rs2;
  logic                  timeout;
  logic                  fetch_go;

  assign op  = ir_q[INSTR_W-1 -: 4];
  assign rd  = ir_q[3*REG_ADDR_W-1 -: REG_ADDR_W];
  assign rs1 = ir_q[2*REG_ADDR_W-1 -: REG_ADDR_W];
  assign rs2 = ir_q[REG_ADDR_W-1:0];

  assign timeout = (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

`ifdef SEQ_SINGLE_STEP_EN
  logic step_wait_q;
  assign fetch_go = !step_wait_q || step;
`else
  assign fetch_go = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FETCH;
      ir_q       <= '0;
      wait_q     <= '0;
      cnt_q      <= '0;
      i_req_q    <= 1'b0;
      d_req_q    <= 1'b0;
      d_we_q     <= 1'b0;
      mem_done_q <= 1'b0;
      r1_q       <= 1'b0;
      r2_q       <= 1'b0;
      r3w_q      <= 1'b0;
      pcl_q      <= 1'b0;
      cmpl_q     <= 1'b0;
      cmpc_q     <= 1'b0;
      lu_q       <= '0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
      a1_q       <= '0;
      a2_q       <= '0;
      a3_q       <= '0;
`ifdef SEQ_SINGLE_STEP_EN
      step_wait_q <= 1'b0;
`endif
    end else begin
      r1_q   <= 1'b0;
      r2_q   <= 1'b0;
      r3w_q  <= 1'b0;
      pcl_q  <= 1'b0;
      cmpl_q <= 1'b0;
      cmpc_q <= 1'b0;
      lu_q   <= '0;
      case (state_q)
        S_FETCH: begin
          if (!i_req_q) begin
            wait_q <= '0;
            if (fetch_go) begin
              i_req_q <= 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
              step_wait_q <= 1'b0;
`endif
            end
          end else if (bus.i_ack) begin
            ir_q    <= bus.i_data;
            i_req_q <= 1'b0;
            state_q <= S_DECODE;
          end else if (timeout) begin
            i_req_q  <= 1'b0;
            fault_q  <= 1'b1;
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        S_DECODE: begin
          a1_q <= rs1;
          a2_q <= rs2;
          a3_q <= rd;
          case (op)
            4'hB, 4'hC: begin
              state_q    <= S_MEM;
              d_req_q    <= 1'b1;
              d_we_q     <= (op == 4'hC);
              r2_q       <= 1'b1;
              r1_q       <= (op == 4'hC);
              wait_q     <= '0;
              mem_done_q <= 1'b0;
            end
            4'hF: begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
              cnt_q    <= cnt_q + CNT_W'(1);
            end
            default: begin
              state_q <= S_EXEC;
              case (op)
                4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
                  r1_q  <= 1'b1;
                  r2_q  <= (op != 4'h1) && (op != 4'h9);
                  lu_q  <= 9'b1 << (op - 4'd1);
                  r3w_q <= 1'b1;
                end
                4'hA: begin
                  r1_q   <= 1'b1;
                  r2_q   <= 1'b1;
                  cmpl_q <= 1'b1;
                  cmpc_q <= 1'b1;
                end
                4'hD, 4'hE: begin
                  if (op == 4'hD || flags[rs2]) begin
                    r1_q  <= 1'b1;
                    lu_q  <= 9'b1;
                    pcl_q <= 1'b1;
                  end
                end
                default: ;
              endcase
            end
          endcase
        end
        S_EXEC: begin
          state_q <= S_FETCH;
          cnt_q   <= cnt_q + CNT_W'(1);
          wait_q  <= '0;
`ifdef SEQ_SINGLE_STEP_EN
          step_wait_q <= 1'b1;
`else
          i_req_q <= 1'b1;
`endif
        end
        S_MEM: begin
          // mem_done_q marks the extra exit cycle after the data acknowledge
          if (mem_done_q) begin
            mem_done_q <= 1'b0;
            state_q    <= S_FETCH;
            cnt_q      <= cnt_q + CNT_W'(1);
            wait_q     <= '0;
`ifdef SEQ_SINGLE_STEP_EN
            step_wait_q <= 1'b1;
`else
            i_req_q <= 1'b1;
`endif
          end else if (bus.d_ack) begin
            d_req_q    <= 1'b0;
            d_we_q     <= 1'b0;
            mem_done_q <= 1'b1;
          end else if (timeout) begin
            d_req_q  <= 1'b0;
            d_we_q   <= 1'b0;
            fault_q  <= 1'b1;
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end else begin
            r1_q   <= r1_q;
            r2_q   <= r2_q;
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        S_HALT: ;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign bus.i_req    = i_req_q;
  assign bus.d_req    = d_req_q;
  assign bus.d_we     = d_we_q;
  assign reg1_read    = r1_q;
  assign reg2_read    = r2_q;
  // load write-back must coincide with the acknowledge, so it bypasses the register
  assign reg3_write   = r3w_q | (d_req_q & ~d_we_q & bus.d_ack);
  assign reg1_addr    = a1_q;
  assign reg2_addr    = a2_q;
  assign reg3_addr    = a3_q;
  assign lu_op        = lu_q;
  assign pc_increment = (state_q == S_FETCH) & i_req_q & bus.i_ack;
  assign pc_load      = pcl_q;
  assign cmp_load     = cmpl_q;
  assign cmp_compare  = cmpc_q;
  assign halted       = halted_q;
  assign fault        = fault_q;
  assign instr_count  = cnt_q;
endmodule
